uart_multi_adc_reporter: RTL

//  Periodic or triggered ASCII reporter for CH_NUM parallel ADC channels over UART.

---
 rtl/uart_multi_adc_reporter.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_multi_adc_reporter.sv
// uart_multi_adc_reporter
//   Periodic or triggered ASCII reporter for CH_NUM parallel ADC channels.
//   Every channel is snapshotted in a single cycle. Each snapshot is then
//   converted to DIGITS BCD digits by a sequential double-dabble, one channel
//   after another. The frame "C0:dddd,C1:dddd,...\r\n" is sent one byte at a
//   time through the internal byte transmitter.
// Ports
//   clk         system clock
//   rst_n       async active-low reset
//   adc_data    CH_NUM*DATA_W bits, channel k = adc_data[k*DATA_W +: DATA_W]
//   trig        one-cycle request for an immediate frame
//   frame_busy  high from the snapshot until the last byte is accepted
//   frame_done  one-cycle pulse after the last byte is accepted
//   overrun     one-cycle pulse when a periodic tick is dropped
//   uart_tx     serial output line, idles high
//
// state  | meaning
// IDLE   | waiting for tick, trig or a pending request
// SNAP   | latch adc_data, clear pending, frame_busy rises
// CONV   | double-dabble, DATA_W cycles per channel
// LOAD   | select the byte at index byte_idx
// REQ    | send_en high until the transmitter reports busy
// ACK    | wait for the transmitter to go idle
// DONE   | frame_done pulse for one cycle

module uart_byte_tx #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_en,
    input  logic [7:0] send_data,
    output logic       send_busy,
    output logic       tx
);
    localparam int CYC = CLK_FRE * 1_000_000 / UART_RATE;

    logic [15:0] cyc_cnt;
    logic [3:0]  bit_idx;
    logic [8:0]  shreg;    // {stop, data[7:0]}. The start bit is driven directly.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_busy <= 1'b0;
            tx        <= 1'b1;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '1;
        end else if (!send_busy) begin
            if (send_en) begin
                send_busy <= 1'b1;
                shreg     <= {1'b1, send_data};
                tx        <= 1'b0;
                cyc_cnt   <= '0;
                bit_idx   <= '0;
            end
        end else if (cyc_cnt == 16'(CYC - 1)) begin
            cyc_cnt <= '0;
            if (bit_idx == 4'd9) begin
                send_busy <= 1'b0;
                tx        <= 1'b1;
            end else begin
                tx      <= shreg[bit_idx];
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
endmodule

module uart_multi_adc_reporter #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200,
    parameter int SEND_FRE  = 2,
    parameter int CH_NUM    = 2,
    parameter int DATA_W    = 10,
    parameter int DIGITS    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CH_NUM*DATA_W-1:0]   adc_data,
    input  logic                       trig,
    output logic                       frame_busy,
    output logic                       frame_done,
    output logic                       overrun,
    output logic                       uart_tx
);
    localparam int BW        = DIGITS * 4;
    localparam int FRAME_LEN = CH_NUM * (3 + DIGITS) + (CH_NUM - 1) + 2;

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam logic [23:0] MAX_VAL = 24'(pow10(DIGITS) - 1);

    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CONV, S_LOAD, S_REQ, S_ACK, S_DONE} state_t;

    state_t                     state;
    logic                       pending;
    logic                       send_en;
    logic                       send_busy;
    logic [7:0]                 send_data;
    logic [CH_NUM*DATA_W-1:0]   snap;
    logic [CH_NUM*BW-1:0]       bcd_all;
    logic [BW-1:0]              work_bcd;
    logic [DATA_W-1:0]          shift_val;
    logic [4:0]                 bit_cnt;
    logic [3:0]                 conv_ch;
    logic [6:0]                 byte_idx;
    logic [3:0]                 out_ch;
    logic [3:0]                 pos;      // byte position inside the current channel field
    logic                       tick;

    generate
        if (SEND_FRE > 0) begin : g_tick
            localparam int unsigned PERIOD = CLK_FRE * 1_000_000 / SEND_FRE;
            logic [31:0] period_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                     period_cnt <= '0;
                else if (period_cnt == PERIOD - 1) period_cnt <= '0;
                else                            period_cnt <= period_cnt + 32'd1;
            end
            assign tick = (period_cnt == PERIOD - 1);
        end else begin : g_no_tick
            assign tick = 1'b0;
        end
    endgenerate

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
    logic [BW-1:0] dabbled;
    logic [BW-1:0] bcd_next;
    logic          sat;
    always_comb begin
        dabbled = work_bcd;
        for (int d = 0; d < DIGITS; d++)
            if (work_bcd[d*4 +: 4] >= 4'd5) dabbled[d*4 +: 4] = work_bcd[d*4 +: 4] + 4'd3;
        bcd_next = {dabbled[BW-2:0], shift_val[DATA_W-1]};
        // Out-of-range values are forced to all nines; the truncated BCD is not used then.
        sat = 24'(snap[conv_ch*DATA_W +: DATA_W]) > MAX_VAL;
    end

    logic [7:0] byte_sel;
    logic [3:0] nib;
    always_comb begin
        nib = 4'h0;
        for (int d = 0; d < DIGITS; d++)
            if (int'(pos) == DIGITS + 2 - d) nib = bcd_all[out_ch*BW + d*4 +: 4];
        byte_sel = 8'h00;
        if (pos == 4'd0)                   byte_sel = 8'h43;                    // 'C'
        else if (pos == 4'd1)              byte_sel = 8'h30 + {4'h0, out_ch};
        else if (pos == 4'd2)              byte_sel = 8'h3A;                    // ':'
        else if (int'(pos) < 3 + DIGITS)   byte_sel = 8'h30 + {4'h0, nib};
        else if (int'(pos) == 3 + DIGITS)  byte_sel = (int'(out_ch) == CH_NUM - 1) ? 8'h0D : 8'h2C;
        else                               byte_sel = 8'h0A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            send_en    <= 1'b0;
            send_data  <= '0;
            snap       <= '0;
            bcd_all    <= '0;
            work_bcd   <= '0;
            shift_val  <= '0;
            bit_cnt    <= '0;
            conv_ch    <= '0;
            byte_idx   <= '0;
            out_ch     <= '0;
            pos        <= '0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            // Requests during a frame merge into one pending frame.
            if (state != S_IDLE && state != S_SNAP) begin
                if (tick || trig) pending <= 1'b1;
                if (tick && pending) overrun <= 1'b1;
            end
            case (state)
                S_IDLE: if (tick || trig || pending) begin
                    state      <= S_SNAP;
                    frame_busy <= 1'b1;
                end
                S_SNAP: begin
                    snap      <= adc_data;
                    pending   <= tick || trig;
                    shift_val <= adc_data[DATA_W-1:0];
                    work_bcd  <= '0;
                    bit_cnt   <= '0;
                    conv_ch   <= '0;
                    state     <= S_CONV;
                end
                S_CONV: begin
                    work_bcd  <= bcd_next;
                    shift_val <= shift_val << 1;
                    bit_cnt   <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'(DATA_W - 1)) begin
                        bcd_all[conv_ch*BW +: BW] <= sat ? {DIGITS{4'h9}} : bcd_next;
                        work_bcd <= '0;
                        bit_cnt  <= '0;
                        if (conv_ch == 4'(CH_NUM - 1)) begin
                            byte_idx <= '0;
                            out_ch   <= '0;
                            pos      <= '0;
                            state    <= S_LOAD;
                        end else begin
                            conv_ch   <= conv_ch + 4'd1;
                            shift_val <= snap[(conv_ch + 4'd1)*DATA_W +: DATA_W];
                        end
                    end
                end
                S_LOAD: begin
                    send_data <= byte_sel;
                    send_en   <= 1'b1;
                    state     <= S_REQ;
                end
                S_REQ: if (send_busy) begin
                    send_en <= 1'b0;
                    state   <= S_ACK;
                end
                S_ACK: if (!send_busy) begin
                    if (byte_idx == 7'(FRAME_LEN - 1)) begin
                        frame_busy <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        byte_idx <= byte_idx + 7'd1;
                        if (int'(pos) == DIGITS + 3 && int'(out_ch) != CH_NUM - 1) begin
                            pos    <= '0;
                            out_ch <= out_ch + 4'd1;
                        end else begin
                            pos <= pos + 4'd1;
                        end
                        state <= S_LOAD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_byte_tx #(.CLK_FRE(CLK_FRE), .UART_RATE(UART_RATE)) u_byte_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_en   (send_en),
        .send_data (send_data),
        .send_busy (send_busy),
        .tx        (uart_tx)
    );
endmodule
